// File: rtl/uart_cmd_initiator.sv
// Host-side command initiator: issues READ/WRITE command bytes over a UART
// byte interface and collects the single response byte for READ.
module uart_cmd_initiator #(
  parameter int CMD_RECV_DATA  = 69,
  parameter int CMD_SEND_DATA  = 42,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       req_read,
  input  logic       req_write,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [7:0] rd_data,
  input  logic       tx_ready,
  output logic       tx_send,
  output logic [7:0] tx_data,
  input  logic       rx_valid,
  input  logic [7:0] rx_data
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_CMD  = 3'd1,
    SEND_DATA = 3'd2,
    WAIT_RESP = 3'd3,
    DONE      = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          op_q, op_d;
  logic [7:0]    byte_q, byte_d;
  logic [7:0]    rd_q, rd_d;
  logic          to_q, to_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    byte_d  = byte_q;
    rd_d    = rd_q;
    to_d    = to_q;
    timer_d = timer_q;
    tx_send = 1'b0;
    tx_data = 8'h00;
    case (state_q)
      IDLE: begin
        if (req_write) begin
          op_d    = 1'b1;
          byte_d  = wr_data;
          state_d = SEND_CMD;
        end else if (req_read) begin
          op_d    = 1'b0;
          state_d = SEND_CMD;
        end
      end
      SEND_CMD: begin
        tx_send = tx_ready;
        tx_data = op_q ? 8'(CMD_RECV_DATA) : 8'(CMD_SEND_DATA);
        if (tx_ready) begin
          if (op_q) begin
            state_d = SEND_DATA;
          end else begin
            state_d = WAIT_RESP;
            timer_d = '0;
          end
        end
      end
      SEND_DATA: begin
        tx_send = tx_ready;
        tx_data = byte_q;
        if (tx_ready) begin
          state_d = DONE;
          to_d    = 1'b0;
        end
      end
      WAIT_RESP: begin
        // a byte arriving in the last cycle beats the timeout
        if (rx_valid) begin
          rd_d    = rx_data;
          to_d    = 1'b0;
          state_d = DONE;
        end else if (timer_q == TMAX) begin
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      byte_q  <= 8'h00;
      rd_q    <= 8'h00;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      byte_q  <= byte_d;
      rd_q    <= rd_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      timer_q <= timer_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = to_q;
  assign rd_data = rd_q;

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// Directed bench for uart_cmd_initiator with a scoreboard of expected
// TX bytes and completion results.
module tb_uart_cmd_initiator;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset_ = 1'b0;
  logic       req_read = 1'b0;
  logic       req_write = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       busy, done, timeout;
  logic [7:0] rd_data;
  logic       tx_ready = 1'b0;
  logic       tx_send;
  logic [7:0] tx_data;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  int n_assert = 0;
  int n_fail = 0;

  logic [7:0] tx_q[$];
  logic [8:0] dn_q[$];

  uart_cmd_initiator #(
    .CMD_RECV_DATA(69),
    .CMD_SEND_DATA(42),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset_(reset_),
    .req_read(req_read),
    .req_write(req_write),
    .wr_data(wr_data),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .rd_data(rd_data),
    .tx_ready(tx_ready),
    .tx_send(tx_send),
    .tx_data(tx_data),
    .rx_valid(rx_valid),
    .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // monitors sample on the falling edge
  always @(negedge clk) begin
    if (reset_ && tx_send) begin
      chk("tx_ready_low_send", 32'(tx_ready), 32'd1);
      chk("tx_unexpected", 32'(tx_q.size() != 0), 32'd1);
      if (tx_q.size() != 0) chk("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
    end
    if (reset_ && done) begin
      chk("done_unexpected", 32'(dn_q.size() != 0), 32'd1);
      if (dn_q.size() != 0) chk("done_result", 32'({timeout, rd_data}),
                                32'(dn_q.pop_front()));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) nxt();
  endtask

  // READ with tx_ready high, response in cycle 6
  task automatic do_read(input logic [7:0] b);
    req_read = 1'b1;
    tx_ready = 1'b1;
    tx_q.push_back(8'd42);
    dn_q.push_back({1'b0, b});
    nxt();
    req_read = 1'b0;
    smp();
    chk("rd_c1_send", 32'(tx_send), 32'd1);
    chk("rd_c1_busy", 32'(busy), 32'd1);
    idle_n(5);
    rx_valid = 1'b1;
    rx_data = b;
    nxt();
    rx_valid = 1'b0;
    smp();
    chk("rd_c7_done", 32'(done), 32'd1);
    chk("rd_c7_to", 32'(timeout), 32'd0);
    nxt();
    smp();
    chk("rd_c8_done", 32'(done), 32'd0);
    chk("rd_c8_busy", 32'(busy), 32'd0);
    chk("rd_c8_data", 32'(rd_data), 32'(b));
  endtask

  initial begin
    int c;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'd0);
    chk("rst_send", 32'(tx_send), 32'd0);
    chk("rst_txd", 32'(tx_data), 32'd0);
    nxt();
    reset_ = 1'b1;
    nxt();

    // READ
    do_read(8'd111);

    // WRITE with tx_ready low in cycles 1-3
    nxt();
    req_write = 1'b1;
    wr_data = 8'hA5;
    tx_ready = 1'b0;
    tx_q.push_back(8'd69);
    tx_q.push_back(8'hA5);
    dn_q.push_back({1'b0, 8'd111});
    for (int k = 1; k <= 3; k++) begin
      nxt();
      req_write = 1'b0;
      smp();
      chk("wr_stall_send", 32'(tx_send), 32'd0);
      chk("wr_stall_busy", 32'(busy), 32'd1);
    end
    nxt();
    tx_ready = 1'b1;
    smp();
    chk("wr_c4_cmd", 32'(tx_data), 32'd69);
    nxt();
    smp();
    chk("wr_c5_data", 32'(tx_data), 32'hA5);
    nxt();
    smp();
    chk("wr_c6_done", 32'(done), 32'd1);
    nxt();

    // timeout READ
    req_read = 1'b1;
    tx_q.push_back(8'd42);
    dn_q.push_back({1'b1, 8'd111});
    c = 0;
    for (int k = 1; k <= 40; k++) begin
      nxt();
      req_read = 1'b0;
      smp();
      c = k;
      if (done) break;
    end
    chk("to_cycle", 32'(c), 32'(TO + 2));
    chk("to_flag", 32'(timeout), 32'd1);
    chk("to_rd_kept", 32'(rd_data), 32'd111);
    nxt();

    // response in last WAIT_RESP cycle
    req_read = 1'b1;
    tx_q.push_back(8'd42);
    dn_q.push_back({1'b0, 8'h3C});
    for (int k = 1; k <= TO + 1; k++) begin
      nxt();
      req_read = 1'b0;
    end
    rx_valid = 1'b1;
    rx_data = 8'h3C;
    nxt();
    rx_valid = 1'b0;
    smp();
    chk("bnd_done", 32'(done), 32'd1);
    chk("bnd_to", 32'(timeout), 32'd0);
    chk("bnd_rd", 32'(rd_data), 32'h3C);
    nxt();

    // both requests -> WRITE; read during busy ignored
    req_read = 1'b1;
    req_write = 1'b1;
    wr_data = 8'h5A;
    tx_q.push_back(8'd69);
    tx_q.push_back(8'h5A);
    dn_q.push_back({1'b0, 8'h3C});
    nxt();
    req_read = 1'b0;
    req_write = 1'b0;
    smp();
    chk("arb_cmd", 32'(tx_data), 32'd69);
    nxt();
    req_read = 1'b1;
    nxt();
    req_read = 1'b0;
    smp();
    chk("arb_done", 32'(done), 32'd1);
    nxt();
    smp();
    chk("ign_busy4", 32'(busy), 32'd0);
    nxt();
    rx_valid = 1'b1;
    rx_data = 8'hFF;
    smp();
    chk("ign_busy5", 32'(busy), 32'd0);
    nxt();
    rx_valid = 1'b0;
    smp();
    chk("ign_rd", 32'(rd_data), 32'h3C);
    chk("ign_busy6", 32'(busy), 32'd0);
    nxt();

    // async reset during WAIT_RESP
    req_read = 1'b1;
    tx_q.push_back(8'd42);
    nxt();
    req_read = 1'b0;
    idle_n(3);
    #2;
    reset_ = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_to", 32'(timeout), 32'd0);
    chk("mr_rd", 32'(rd_data), 32'd0);
    chk("mr_send", 32'(tx_send), 32'd0);
    chk("mr_txd", 32'(tx_data), 32'd0);
    nxt();
    reset_ = 1'b1;
    nxt();
    do_read(8'd111);
    idle_n(2);

    chk("tx_q_empty", 32'(tx_q.size()), 32'd0);
    chk("dn_q_empty", 32'(dn_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
